// File: rtl/pc_hazard_ctrl.sv
// pc_hazard_ctrl: PC-select and pipeline-flush controller for a 5-stage in-order core.
//
// Decides the PC source and the pipeline flushes each cycle. The events it arbitrates are:
// memory wait, JALR and taken-branch redirects, and load-use hazards. A redirect that arrives
// during a memory wait is remembered and issued once the memory is ready again.
//
// Ports:
//   clk, arst             clock (rising edge), asynchronous active-high reset
//   mem_wait              memory not ready; the whole pipeline holds
//   ex_is_load, ex_rd     EX-stage load flag and destination register
//   id_rs1/2, id_use_rs1/2 ID-stage source registers and their read enables
//   ex_jalr               EX-stage JALR resolved this cycle
//   ex_branch_taken       EX-stage branch resolved taken this cycle
//   stall_vald            hold PC (one-hot-or-zero with jalr_vald/branch_vald)
//   jalr_vald             select JALR target
//   branch_vald           select branch target
//   if_id_flush           flush IF/ID register
//   id_ex_flush           flush/bubble ID/EX register
//   ctrl_state            current state (0 RUN, 1 MEM_WAIT, 2 FLUSH)
//   err_timeout           sticky flag, memory wait lasted TIMEOUT cycles
//   redirect_cnt          saturating count of redirect cycles
//   stall_cnt             saturating count of stall cycles
module pc_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        mem_wait,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_jalr,
    input  logic        ex_branch_taken,
    output logic        stall_vald,
    output logic        jalr_vald,
    output logic        branch_vald,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  ctrl_state,
    output logic        err_timeout,
    output logic [15:0] redirect_cnt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pend_jalr_q, pend_jalr_d;
    logic        pend_branch_q, pend_branch_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        load_use;
    logic [7:0]  wait_inc;

    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Next state and all PC/flush outputs.
    always_comb begin
        state_d       = state_q;
        pend_jalr_d   = pend_jalr_q;
        pend_branch_d = pend_branch_q;
        stall_vald    = 1'b0;
        jalr_vald     = 1'b0;
        branch_vald   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;

        case (state_q)
            StRun: begin
                if (mem_wait) begin
                    // Remember the redirect; it is issued once memory is ready.
                    stall_vald    = 1'b1;
                    pend_jalr_d   = ex_jalr;
                    pend_branch_d = ex_branch_taken && !ex_jalr;
                    state_d       = StMemWait;
                end else if (ex_jalr) begin
                    jalr_vald   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = StFlush;
                end else if (ex_branch_taken) begin
                    branch_vald = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = StFlush;
                end else if (load_use) begin
                    // Hold PC and IF/ID, insert a bubble into EX.
                    stall_vald  = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end

            StMemWait: begin
                if (mem_wait) begin
                    stall_vald = 1'b1;
                end else begin
                    if (pend_jalr_q) begin
                        jalr_vald   = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = StFlush;
                    end else if (pend_branch_q) begin
                        branch_vald = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = StFlush;
                    end else begin
                        state_d = StRun;
                    end
                    pend_jalr_d   = 1'b0;
                    pend_branch_d = 1'b0;
                end
            end

            StFlush: begin
                // Wrong-path instruction in IF/ID is discarded; redirect inputs are stale.
                if_id_flush   = 1'b1;
                stall_vald    = mem_wait;
                pend_jalr_d   = 1'b0;
                pend_branch_d = 1'b0;
                state_d       = mem_wait ? StMemWait : StRun;
            end

            default: begin
                state_d       = StRun;
                pend_jalr_d   = 1'b0;
                pend_branch_d = 1'b0;
            end
        endcase
    end

    // Memory-wait watchdog.
    assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    always_comb begin
        wait_cnt_d = 8'd0;
        err_d      = err_q;
        if ((state_q == StMemWait) && mem_wait) begin
            wait_cnt_d = wait_inc;
            if (32'(wait_inc) >= TIMEOUT) begin
                err_d = 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if ((jalr_vald || branch_vald) && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
        if (stall_vald && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q        <= StRun;
            pend_jalr_q    <= 1'b0;
            pend_branch_q  <= 1'b0;
            wait_cnt_q     <= 8'd0;
            err_q          <= 1'b0;
            redirect_cnt_q <= 16'd0;
            stall_cnt_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            pend_jalr_q    <= pend_jalr_d;
            pend_branch_q  <= pend_branch_d;
            wait_cnt_q     <= wait_cnt_d;
            err_q          <= err_d;
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign ctrl_state   = state_q;
    assign err_timeout  = err_q;
    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
module tb_pc_hazard_ctrl;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        mem_wait = 1'b0;
    logic        ex_is_load = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic        ex_jalr = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        stall_vald, jalr_vald, branch_vald, if_id_flush, id_ex_flush;
    logic [1:0]  ctrl_state;
    logic        err_timeout;
    logic [15:0] redirect_cnt, stall_cnt;

    pc_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .arst            (arst),
        .mem_wait        (mem_wait),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_jalr         (ex_jalr),
        .ex_branch_taken (ex_branch_taken),
        .stall_vald      (stall_vald),
        .jalr_vald       (jalr_vald),
        .branch_vald     (branch_vald),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ctrl_state      (ctrl_state),
        .err_timeout     (err_timeout),
        .redirect_cnt    (redirect_cnt),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Expected {ctrl_state, stall, jalr, branch, if_id_flush, id_ex_flush} per cycle.
    logic [6:0]  exp_q[$];
    logic [15:0] exp_stall_cnt = 16'd0;
    logic [15:0] exp_redir_cnt = 16'd0;
    logic        exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ev(input logic [1:0] st, input logic s, input logic j,
                                      input logic b, input logic fi, input logic fx);
        return {st, s, j, b, fi, fx};
    endfunction

    // Entered just after a rising edge; drives one cycle and checks it on the falling edge.
    task automatic step(input string tag, input logic mw, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic jr,
                        input logic br, input logic [6:0] exp);
        logic [6:0] e;
        mem_wait        = mw;
        ex_is_load      = ld;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_use_rs1      = u1;
        ex_jalr         = jr;
        ex_branch_taken = br;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".out"}, 32'({ctrl_state, stall_vald, jalr_vald, branch_vald,
                                  if_id_flush, id_ex_flush}), 32'(e));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall_cnt));
        check({tag, ".redir_cnt"}, 32'(redirect_cnt), 32'(exp_redir_cnt));
        check({tag, ".err"}, 32'(err_timeout), 32'(exp_err));
        if (e[4] && exp_stall_cnt != 16'hFFFF) exp_stall_cnt++;
        if ((e[3] || e[2]) && exp_redir_cnt != 16'hFFFF) exp_redir_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst.out", 32'({ctrl_state, stall_vald, jalr_vald, branch_vald,
                             if_id_flush, id_ex_flush}), 32'd0);
        check("rst.cnt", 32'({redirect_cnt, stall_cnt}), 32'd0);
        check("rst.err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        // Load-use on rs1
        step("lu_rs1", 0, 1, 5'd5, 5'd5, 1, 0, 0, ev(0, 1, 0, 0, 0, 1));
        idle("lu_idle", ev(0, 0, 0, 0, 0, 0));
        // Load-use on rs2 only
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        step("lu_rs2", 0, 1, 5'd7, 5'd3, 1, 0, 0, ev(0, 1, 0, 0, 0, 1));
        id_use_rs2 = 1'b0;
        step("lu_rs2_off", 0, 1, 5'd7, 5'd3, 1, 0, 0, ev(0, 0, 0, 0, 0, 0));
        // No hazard: mismatch, unused source, not a load
        step("lu_miss", 0, 1, 5'd5, 5'd6, 1, 0, 0, ev(0, 0, 0, 0, 0, 0));
        step("lu_unused", 0, 1, 5'd5, 5'd5, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
        step("lu_noload", 0, 0, 5'd5, 5'd5, 1, 0, 0, ev(0, 0, 0, 0, 0, 0));
        // Load to x0 never stalls
        step("lu_x0", 0, 1, 5'd0, 5'd0, 1, 0, 0, ev(0, 0, 0, 0, 0, 0));

        // JALR beats branch and load-use
        step("jb", 0, 1, 5'd5, 5'd5, 1, 1, 1, ev(0, 0, 1, 0, 1, 1));
        step("jb_flush", 0, 0, 5'd0, 5'd0, 0, 1, 1, ev(2, 0, 0, 0, 1, 0));
        idle("jb_run", ev(0, 0, 0, 0, 0, 0));

        // Branch beats load-use; FLUSH with mem_wait goes to MEM_WAIT
        step("br", 0, 1, 5'd5, 5'd5, 1, 0, 1, ev(0, 0, 0, 1, 1, 1));
        step("br_flush_mw", 1, 0, 5'd0, 5'd0, 0, 0, 1, ev(2, 1, 0, 0, 1, 0));
        idle("br_mw_exit", ev(1, 0, 0, 0, 0, 0));
        idle("br_run", ev(0, 0, 0, 0, 0, 0));

        // Branch captured during memory wait
        step("mwb1", 1, 0, 5'd0, 5'd0, 0, 0, 1, ev(0, 1, 0, 0, 0, 0));
        step("mwb2", 1, 0, 5'd0, 5'd0, 0, 0, 1, ev(1, 1, 0, 0, 0, 0));
        step("mwb3", 1, 0, 5'd0, 5'd0, 0, 0, 1, ev(1, 1, 0, 0, 0, 0));
        idle("mwb_exit", ev(1, 0, 0, 1, 1, 1));
        idle("mwb_flush", ev(2, 0, 0, 0, 1, 0));
        idle("mwb_run", ev(0, 0, 0, 0, 0, 0));

        // JALR captured; later redirect inputs ignored
        step("mwj1", 1, 0, 5'd0, 5'd0, 0, 1, 1, ev(0, 1, 0, 0, 0, 0));
        step("mwj_exit", 0, 0, 5'd0, 5'd0, 0, 0, 1, ev(1, 0, 1, 0, 1, 1));
        step("mwj_flush", 0, 0, 5'd0, 5'd0, 0, 1, 0, ev(2, 0, 0, 0, 1, 0));
        idle("mwj_run", ev(0, 0, 0, 0, 0, 0));

        // Timeout at 4 consecutive MEM_WAIT cycles, sticky
        step("to_run", 1, 0, 5'd0, 5'd0, 0, 0, 0, ev(0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            step("to_mw", 1, 0, 5'd0, 5'd0, 0, 0, 0, ev(1, 1, 0, 0, 0, 0));
        end
        exp_err = 1'b1;
        step("to_mw5", 1, 0, 5'd0, 5'd0, 0, 0, 0, ev(1, 1, 0, 0, 0, 0));
        idle("to_exit", ev(1, 0, 0, 0, 0, 0));
        idle("to_run2", ev(0, 0, 0, 0, 0, 0));

        // Reset during MEM_WAIT with a pending JALR
        step("rmw1", 1, 0, 5'd0, 5'd0, 0, 1, 0, ev(0, 1, 0, 0, 0, 0));
        step("rmw2", 1, 0, 5'd0, 5'd0, 0, 0, 0, ev(1, 1, 0, 0, 0, 0));
        mem_wait = 1'b0;
        arst = 1'b1;
        #1;
        check("arst.state", 32'(ctrl_state), 32'd0);
        check("arst.jalr", 32'(jalr_vald), 32'd0);
        check("arst.cnt", 32'({redirect_cnt, stall_cnt}), 32'd0);
        check("arst.err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        exp_stall_cnt = 16'd0;
        exp_redir_cnt = 16'd0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        idle("arst_run", ev(0, 0, 0, 0, 0, 0));
        idle("arst_run2", ev(0, 0, 0, 0, 0, 0));

        // Saturate stall_cnt
        for (int i = 0; i < 65540; i++) begin
            step("sat", 0, 1, 5'd9, 5'd9, 1, 0, 0, ev(0, 1, 0, 0, 0, 1));
        end
        check("sat.final", 32'(stall_cnt), 32'h0000FFFF);
        step("sat_hold", 0, 1, 5'd9, 5'd9, 1, 0, 0, ev(0, 1, 0, 0, 0, 1));
        check("sat.hold", 32'(stall_cnt), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
